// File: rtl/wm_pkg.sv
// Shared definitions for the washing-machine control blocks: FSM state
// encoding and default timing for the water inlet arbiter.
package wm_pkg;

  // One-hot encoding, same style as the per-machine controller FSM.
  typedef enum logic [2:0] {
    IDLE = 3'b001,
    OPEN = 3'b010,
    GAP  = 3'b100
  } state_t;

  localparam int DEF_MAX_HOLD   = 8;
  localparam int DEF_GAP_CYCLES = 2;

endpackage

// File: rtl/water_inlet_arbiter_if.sv
// Bundle between the machine controllers (master) and the inlet arbiter (slave).
interface water_inlet_arbiter_if #(
  parameter int N_MACH = 4
);
  logic [N_MACH-1:0] fill_req;
  logic [N_MACH-1:0] fill_done;
  logic              shutoff;
  logic [N_MACH-1:0] grant;
  logic              valve_open;
  logic [N_MACH-1:0] timeout_err;
  logic              busy;

  modport master (
    output fill_req, fill_done, shutoff,
    input  grant, valve_open, timeout_err, busy
  );

  modport slave (
    input  fill_req, fill_done, shutoff,
    output grant, valve_open, timeout_err, busy
  );
endinterface

// File: rtl/water_inlet_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr,
// wrapping modulo N_MACH.
module rr_pick #(
  parameter int N_MACH = 4,
  parameter int PTR_W  = 2
) (
  input  logic [N_MACH-1:0] req,
  input  logic [PTR_W-1:0]  ptr,
  output logic              valid,
  output logic [PTR_W-1:0]  index
);
  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(N_MACH);

  // rot[gi] is the request sitting gi places above the pointer.
  logic [N_MACH-1:0] rot;

  generate
    for (genvar gi = 0; gi < N_MACH; gi++) begin : g_rot
      logic [PTR_W:0] sum;
      logic [PTR_W:0] idx;
      assign sum     = {1'b0, ptr} + (PTR_W+1)'(gi);
      assign idx     = (sum >= N_EXT) ? sum - N_EXT : sum;
      assign rot[gi] = req[idx[PTR_W-1:0]];
    end
  endgenerate

  logic [PTR_W:0] off;
  logic [PTR_W:0] abs_idx;

  always_comb begin
    valid   = 1'b0;
    off     = '0;
    abs_idx = '0;
    for (int k = N_MACH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        valid = 1'b1;
        off   = (PTR_W+1)'(k);
      end
    end
    abs_idx = {1'b0, ptr} + off;
    if (abs_idx >= N_EXT) begin
      abs_idx = abs_idx - N_EXT;
    end
    index = abs_idx[PTR_W-1:0];
  end
endmodule

// File: rtl/water_inlet_arbiter.sv
// Shares one mains inlet valve between N_MACH machines: round-robin grant,
// per-grant hold limit, and a valve-off settle gap after every release.
module water_inlet_arbiter
  import wm_pkg::*;
#(
  parameter int N_MACH     = 4,
  parameter int MAX_HOLD   = DEF_MAX_HOLD,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int CNT_W      = 8
) (
  input logic                  clk,
  input logic                  res,
  water_inlet_arbiter_if.slave bus
);
  localparam int PTR_W = (N_MACH > 1) ? $clog2(N_MACH) : 1;

  state_t              state_reg, state_next;
  logic [N_MACH-1:0]   grant_reg, grant_next;
  logic [N_MACH-1:0]   tout_reg, tout_next;
  logic                valve_reg, valve_next;
  logic                busy_reg, busy_next;
  logic [PTR_W-1:0]    ptr_reg, ptr_next;
  logic [PTR_W-1:0]    owner_reg, owner_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;

  logic                pick_valid;
  logic [PTR_W-1:0]    pick_idx;
  logic [PTR_W-1:0]    owner_inc;
  logic                owner_done, owner_req, at_limit, gap_end, release_now;

  rr_pick #(
    .N_MACH (N_MACH),
    .PTR_W  (PTR_W)
  ) u_pick (
    .req   (bus.fill_req),
    .ptr   (ptr_reg),
    .valid (pick_valid),
    .index (pick_idx)
  );

  assign owner_done  = bus.fill_done[owner_reg];
  assign owner_req   = bus.fill_req[owner_reg];
  assign at_limit    = (cnt_reg == CNT_W'(MAX_HOLD - 1));
  assign gap_end     = (cnt_reg == CNT_W'(GAP_CYCLES - 1));
  assign owner_inc   = (owner_reg == PTR_W'(N_MACH - 1)) ? '0 : owner_reg + PTR_W'(1);
  assign release_now = owner_done || !owner_req || bus.shutoff || at_limit;

  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    tout_next  = '0;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.shutoff && pick_valid) begin
          state_next = OPEN;
          grant_next = N_MACH'(1) << pick_idx;
          owner_next = pick_idx;
          cnt_next   = '0;
        end
      end
      OPEN: begin
        if (release_now) begin
          // Only a genuine hold-limit expiry is a timeout; done, drop and shutoff win.
          if (at_limit && !owner_done && owner_req && !bus.shutoff) begin
            tout_next = grant_reg;
          end
          grant_next = '0;
          ptr_next   = owner_inc;
          cnt_next   = '0;
          state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      GAP: begin
        if (gap_end) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        cnt_next   = '0;
      end
    endcase
    valve_next = |grant_next;
    busy_next  = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_reg <= IDLE;
      grant_reg <= '0;
      tout_reg  <= '0;
      valve_reg <= 1'b0;
      busy_reg  <= 1'b0;
      ptr_reg   <= '0;
      owner_reg <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      tout_reg  <= tout_next;
      valve_reg <= valve_next;
      busy_reg  <= busy_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign bus.grant       = grant_reg;
  assign bus.timeout_err = tout_reg;
  assign bus.valve_open  = valve_reg;
  assign bus.busy        = busy_reg;
endmodule
